// File: rtl/ec_core_rconv.sv
// Redundant-to-binary converter: z = (zp - zn) mod P256 on a 64-bit limb datapath, constant latency.
// Optional macro EC_RCONV_FULLRED_EN adds a final conditional subtraction of P (zp may then be any 256-bit value).
module ec_core_rconv (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cv_start,
    input  logic         cv_clr,
    input  logic [255:0] zp,
    input  logic [255:0] zn,
    output logic         cv_busy,
    output logic         cv_done,
    output logic [255:0] z
);

    localparam logic [255:0] P =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

`ifdef EC_RCONV_FULLRED_EN
    typedef enum logic [2:0] {S_IDLE, S_SUB, S_ADDP, S_RED, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SUB, S_ADDP, S_DONE} state_t;
`endif

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         cf_q, cf_d;
    logic         neg_q, neg_d;
    logic [255:0] w_q, w_d;
    logic [255:0] zn_q, zn_d;
    logic [255:0] z_q, z_d;
`ifdef EC_RCONV_FULLRED_EN
    logic [255:0] t_q, t_d;
    logic [64:0]  trial65;
`endif

    logic [7:0]   idx;
    logic [63:0]  limb_w, limb_zn, limb_p;
    logic [64:0]  sub65, add65;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cf_d    = cf_q;
        neg_d   = neg_q;
        w_d     = w_q;
        zn_d    = zn_q;
        z_d     = z_q;
`ifdef EC_RCONV_FULLRED_EN
        t_d     = t_q;
`endif
        idx     = {cnt_q, 6'd0};
        limb_w  = w_q[idx +: 64];
        limb_zn = zn_q[idx +: 64];
        limb_p  = P[idx +: 64];
        // The same flag register carries the borrow in SUB/RED and the carry in ADDP.
        sub65   = {1'b0, limb_w} - {1'b0, limb_zn} - {64'd0, cf_q};
        add65   = {1'b0, limb_w} + {1'b0, limb_p & {64{neg_q}}} + {64'd0, cf_q};
`ifdef EC_RCONV_FULLRED_EN
        trial65 = {1'b0, limb_w} - {1'b0, limb_p} - {64'd0, cf_q};
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (cv_start) begin
                    w_d     = zp;
                    zn_d    = zn;
                    cf_d    = 1'b0;
                    neg_d   = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                w_d[idx +: 64] = sub65[63:0];
                cf_d  = sub65[64];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    neg_d   = sub65[64];
                    cf_d    = 1'b0;
                    state_d = S_ADDP;
                end
            end
            S_ADDP: begin
                w_d[idx +: 64] = add65[63:0];
                cf_d  = add65[64];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    cf_d    = 1'b0;
`ifdef EC_RCONV_FULLRED_EN
                    state_d = S_RED;
`else
                    z_d     = w_d;
                    state_d = S_DONE;
`endif
                end
            end
`ifdef EC_RCONV_FULLRED_EN
            S_RED: begin
                t_d[idx +: 64] = trial65[63:0];
                cf_d  = trial65[64];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    // A final borrow means w < P already, so keep w.
                    cf_d    = 1'b0;
                    z_d     = trial65[64] ? w_q : t_d;
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (cv_clr) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
            cf_d    = 1'b0;
            neg_d   = 1'b0;
            w_d     = '0;
            zn_d    = '0;
            z_d     = '0;
`ifdef EC_RCONV_FULLRED_EN
            t_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            cf_q    <= 1'b0;
            neg_q   <= 1'b0;
            w_q     <= '0;
            zn_q    <= '0;
            z_q     <= '0;
`ifdef EC_RCONV_FULLRED_EN
            t_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cf_q    <= cf_d;
            neg_q   <= neg_d;
            w_q     <= w_d;
            zn_q    <= zn_d;
            z_q     <= z_d;
`ifdef EC_RCONV_FULLRED_EN
            t_q     <= t_d;
`endif
        end
    end

    assign cv_done = (state_q == S_DONE);
`ifdef EC_RCONV_FULLRED_EN
    assign cv_busy = (state_q == S_SUB) || (state_q == S_ADDP) || (state_q == S_RED);
`else
    assign cv_busy = (state_q == S_SUB) || (state_q == S_ADDP);
`endif
    assign z = z_q;

endmodule

// File: tb/tb_ec_core_rconv.sv
// Randomized self-checking bench for ec_core_rconv against a cycle-level behavioural model.
module tb_ec_core_rconv;

    localparam logic [255:0] P =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
`ifdef EC_RCONV_FULLRED_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 9;
`endif

    logic         clk, rst_n, cv_start, cv_clr;
    logic [255:0] zp, zn;
    logic         cv_busy, cv_done;
    logic [255:0] z;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    ec_core_rconv dut (
        .clk(clk), .rst_n(rst_n), .cv_start(cv_start), .cv_clr(cv_clr),
        .zp(zp), .zn(zn), .cv_busy(cv_busy), .cv_done(cv_done), .z(z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] ref_conv(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] aa, r;
        aa = {1'b0, a};
        if (aa >= {1'b0, P}) aa = aa - {1'b0, P};
        if (aa >= {1'b0, b}) r = aa - {1'b0, b};
        else                 r = aa + {1'b0, P} - {1'b0, b};
        return r[255:0];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: cycle number since acceptance, pending result, visible result.
    int           cyc_m;
    logic [255:0] pend_m, z_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_m <= 0;
            z_m   <= '0;
        end else if (cv_clr) begin
            cyc_m <= 0;
            z_m   <= '0;
        end else if ((cyc_m == 0 || cyc_m == LAT) && cv_start) begin
            cyc_m  <= 1;
            pend_m <= ref_conv(zp, zn);
        end else if (cyc_m > 0 && cyc_m < LAT) begin
            cyc_m <= cyc_m + 1;
            if (cyc_m == LAT - 1) z_m <= pend_m;
        end else begin
            cyc_m <= 0;
        end
    end

    always @(negedge clk) begin
        if (check_en && rst_n) begin
            chk("cyc_busy", {255'd0, cv_busy}, {255'd0, (cyc_m > 0 && cyc_m < LAT)});
            chk("cyc_done", {255'd0, cv_done}, {255'd0, (cyc_m == LAT)});
            chk("cyc_z", z, z_m);
        end
    end

    // Starts one conversion and waits for its done pulse; returns at the done-cycle negedge.
    task automatic run_op(input string name, input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] exp, input bit b2b);
        int n, nb;
        if (!b2b) @(negedge clk);
        zp = a; zn = b; cv_start = 1'b1;
        @(negedge clk);
        cv_start = 1'b0;
        n  = 1;
        nb = cv_busy ? 1 : 0;
        while (!cv_done && n < 40) begin
            @(negedge clk);
            n++;
            if (cv_busy) nb++;
        end
        chk_int({name, "_lat"}, n, LAT);
        chk_int({name, "_busy"}, nb, LAT - 1);
        chk({name, "_z"}, z, exp);
        $display("[TB] op %s zp=%h zn=%h z=%h cycles=%0d", name, a, b, z, n);
    endtask

    initial begin
        int n, dones;
        logic [255:0] a, b;
        rst_n = 1'b0; cv_start = 1'b0; cv_clr = 1'b0; zp = '0; zn = '0;
        #3;
        chk("rst_busy", {255'd0, cv_busy}, 256'd0);
        chk("rst_done", {255'd0, cv_done}, 256'd0);
        chk("rst_z", z, 256'd0);
        // Literal pins on the model itself.
        chk("model_basic", ref_conv(256'd5, 256'd3), 256'd2);
        chk("model_neg", ref_conv(256'd3, 256'd5),
            256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFD);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;

        run_op("basic", 256'd5, 256'd3, 256'd2, 1'b0);
        run_op("negwrap", 256'd3, 256'd5,
               256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFD, 1'b0);
        run_op("equal", P - 256'd1, P - 256'd1, 256'd0, 1'b0);
        run_op("limb", 256'h1_0000_0000_0000_0000, 256'd1, 256'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Start re-asserted at cycle 3 with other operands must be ignored.
        @(negedge clk);
        zp = 256'd5; zn = 256'd3; cv_start = 1'b1;
        n = 0;
        while (n == 0 || (!cv_done && n < 40)) begin
            @(negedge clk);
            n++;
            cv_start = (n == 3);
            if (n == 3) begin zp = 256'd100; zn = 256'd1; end
        end
        cv_start = 1'b0;
        chk_int("restart_lat", n, LAT);
        chk("restart_z", z, 256'd2);
        $display("[TB] op restart zp=5 zn=3 z=%h cycles=%0d", z, n);

        // Clear at cycle 4 aborts and zeroes z.
        @(negedge clk);
        zp = 256'd9; zn = 256'd1; cv_start = 1'b1;
        @(negedge clk);
        cv_start = 1'b0;
        repeat (3) @(negedge clk);
        cv_clr = 1'b1;
        @(negedge clk);
        cv_clr = 1'b0;
        chk("clr_busy", {255'd0, cv_busy}, 256'd0);
        chk("clr_z", z, 256'd0);
        dones = 0;
        repeat (LAT + 3) begin @(negedge clk); if (cv_done) dones++; end
        chk_int("clr_nodone", dones, 0);
        $display("[TB] op clear z=%h dones=%0d", z, dones);

        // Clear together with start: stays idle.
        run_op("pre_cs", 256'd4, 256'd1, 256'd3, 1'b0);
        @(negedge clk);
        zp = 256'd8; zn = 256'd1; cv_start = 1'b1; cv_clr = 1'b1;
        @(negedge clk);
        cv_start = 1'b0; cv_clr = 1'b0;
        chk("clrstart_busy", {255'd0, cv_busy}, 256'd0);
        dones = 0;
        repeat (LAT + 3) begin @(negedge clk); if (cv_done) dones++; end
        chk_int("clrstart_nodone", dones, 0);
        chk("clrstart_z", z, 256'd0);
        $display("[TB] op clr+start z=%h dones=%0d", z, dones);

        // Back-to-back start in the DONE cycle.
        run_op("b2b_first", 256'd5, 256'd3, 256'd2, 1'b0);
        run_op("b2b_second", 256'd7, 256'd0, 256'd7, 1'b1);

        // Asynchronous reset in the middle of ADDP.
        @(negedge clk);
        zp = 256'd9; zn = 256'd2; cv_start = 1'b1;
        @(negedge clk);
        cv_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {255'd0, cv_busy}, 256'd0);
        chk("arst_done", {255'd0, cv_done}, 256'd0);
        chk("arst_z", z, 256'd0);
        $display("[TB] op async reset mid-ADDP z=%h", z);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef EC_RCONV_FULLRED_EN
        run_op("fullred", {256{1'b1}}, 256'd0,
               256'h00000000FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF000000000000000000000000, 1'b0);
`endif

        for (int i = 0; i < 150; i++) begin
            a = rnd256();
            b = rnd256();
            if (b >= P) b = b - P;
`ifndef EC_RCONV_FULLRED_EN
            if (a >= P) a = a - P;
`endif
            if (i % 10 == 0) b = a;
            run_op($sformatf("rnd%0d", i), a, b, ref_conv(a, b), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
